chi_txflit_link: RTL and testbench

- Downstream consumer of the TX flit RAM: it reads stored flits from RAM port B and drives them onto the CHI TX link channel (TXFLITPEND/TXFLITV/TXFLIT) under L-credit flow control.
- A host-side sequencer hands it a job (start slot, flit count). The block streams the flits, tracks link credits and pulses done.
- One instance sits per TX channel (REQ/RSP/DAT).

---
 rtl/chi_tx_pkg.sv | 17 +
 rtl/chi_tx_crd_cnt.sv | 37 +++
 rtl/chi_txflit_link.sv | 126 ++++++++++++
 tb/tb_chi_txflit_link.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chi_tx_pkg.sv
// Shared types and constants for the CHI TX flit link.
// Holds FSM encoding, credit width and the credit-limit check.
package chi_tx_pkg;

  localparam int CRD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

  function automatic bit crd_max_ok(input int m);
    return (m > 0) && (m < (1 << CRD_W));
  endfunction

endpackage

// File: rtl/chi_tx_crd_cnt.sv
// Saturating L-credit counter with sticky overflow flag.
// A clear drops all credits while the link is stopped.
module chi_tx_crd_cnt
  import chi_tx_pkg::*;
#(
  parameter int MAX_CRD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CRD_W-1:0] cnt,
  output logic             err
);

  localparam logic [CRD_W-1:0] MAXV =
    CRD_W'(MAX_CRD);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt == MAXV) begin
        err <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (dec && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/chi_txflit_link.sv
// Streams stored flits from RAM port B onto the CHI TX link.
// Credits are reserved at read issue, so the read pipe never stalls.
module chi_txflit_link
  import chi_tx_pkg::*;
#(
  parameter int AWIDTH     = 12,
  parameter int FLIT_WIDTH = 128,
  parameter int RAM_LAT    = 2,
  parameter int MAX_CRD    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AWIDTH-1:0]     req_addr,
  input  logic [AWIDTH:0]       req_count,
  output logic                  done,
  output logic                  crd_err,
  output logic                  ram_en_b,
  output logic [AWIDTH-1:0]     ram_addr_b,
  output logic                  ram_oreg_ce_b,
  input  logic [FLIT_WIDTH-1:0] ram_rd_data_b,
  input  logic                  link_active,
  input  logic                  txlcrdv,
  output logic                  txflitpend,
  output logic                  txflitv,
  output logic [FLIT_WIDTH-1:0] txflit,
  output logic [CRD_W-1:0]      crd_avail
);

  if (!crd_max_ok(MAX_CRD) ||
      !(RAM_LAT == 1 || RAM_LAT == 2)) begin : g_bad
    $error("chi_txflit_link: bad parameter");
  end

  tx_state_t          state;
  tx_state_t          state_nxt;
  logic [AWIDTH-1:0]  addr_q;
  logic [AWIDTH:0]    rem_q;
  logic [RAM_LAT-1:0] vld_sr;
  logic               issue;
  logic               accept;
  logic               in_flight;
  logic               drain_end;
  logic               last_iss;

  assign in_flight = |vld_sr;
  assign issue     = (state == ST_RUN) &&
                     link_active &&
                     (crd_avail != '0);
  assign accept    = (state == ST_IDLE) &&
                     req_valid &&
                     (req_count != '0);
  assign last_iss  = issue &&
                     (rem_q == (AWIDTH+1)'(1));
  assign drain_end = (state == ST_DRAIN) &&
                     !in_flight && txflitv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept)    state_nxt = ST_RUN;
      ST_RUN:   if (last_iss)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      addr_q <= req_addr;
      rem_q  <= req_count;
    end else if (issue) begin
      addr_q <= addr_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
    end
  end

  // Bit k set: a read issued k+1 cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr  <= '0;
      txflitv <= 1'b0;
      txflit  <= '0;
      done    <= 1'b0;
    end else begin
      vld_sr  <= RAM_LAT'({vld_sr, issue});
      txflitv <= vld_sr[RAM_LAT-1];
      done    <= drain_end;
      if (vld_sr[RAM_LAT-1]) begin
        txflit <= ram_rd_data_b;
      end
    end
  end

  chi_tx_crd_cnt #(
    .MAX_CRD (MAX_CRD)
  ) u_crd (
    .clk (clk),
    .rst (rst),
    .inc (txlcrdv),
    .dec (issue),
    .clr (!link_active && !in_flight),
    .cnt (crd_avail),
    .err (crd_err)
  );

  assign req_ready     = (state == ST_IDLE);
  assign ram_en_b      = issue;
  assign ram_addr_b    = addr_q;
  assign ram_oreg_ce_b = 1'b1;
  assign txflitpend    = (state == ST_RUN) ||
                         in_flight || txflitv;

endmodule

// File: tb/tb_chi_txflit_link.sv
// Randomised and directed bench for chi_txflit_link.
// A timing-level scoreboard predicts every output each cycle.
module tb_chi_txflit_link;

  localparam int AW = 4;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [AW:0]   req_count;
  logic          done;
  logic          crd_err;
  logic          ram_en_b;
  logic [AW-1:0] ram_addr_b;
  logic          ram_oreg_ce_b;
  logic [FW-1:0] ram_rd_data_b;
  logic          link_active;
  logic          txlcrdv;
  logic          txflitpend;
  logic          txflitv;
  logic [FW-1:0] txflit;
  logic [3:0]    crd_avail;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chi_txflit_link #(
    .AWIDTH     (AW),
    .FLIT_WIDTH (FW),
    .RAM_LAT    (2),
    .MAX_CRD    (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_count     (req_count),
    .done          (done),
    .crd_err       (crd_err),
    .ram_en_b      (ram_en_b),
    .ram_addr_b    (ram_addr_b),
    .ram_oreg_ce_b (ram_oreg_ce_b),
    .ram_rd_data_b (ram_rd_data_b),
    .link_active   (link_active),
    .txlcrdv       (txlcrdv),
    .txflitpend    (txflitpend),
    .txflitv       (txflitv),
    .txflit        (txflit),
    .crd_avail     (crd_avail)
  );

  // RAM with a two-cycle read latency
  logic [FW-1:0] mem [16];
  logic [FW-1:0] rs1, rs2;
  always @(posedge clk) begin
    if (ram_en_b) rs1 <= mem[ram_addr_b];
    rs2 <= rs1;
  end
  assign ram_rd_data_b = rs2;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Scoreboard: each issued read becomes an output
  // expected exactly 3 cycles after the issue cycle.
  typedef struct {
    int            due;
    logic [FW-1:0] d;
  } ent_t;

  ent_t          q[$];
  int            cyc = 0;
  bit            started = 0;
  bit            m_act;
  int            m_iss_left;
  int            m_left;
  logic [AW-1:0] m_addr;
  int            m_crd;
  bit            m_err;
  logic [FW-1:0] m_last;
  int            m_done_cyc;
  bit            s_iss, s_inf, s_was;

  function automatic bit m_issue();
    return m_act && (m_iss_left > 0) &&
           (link_active === 1'b1) && (m_crd > 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_act = 0; m_iss_left = 0; m_left = 0;
      m_addr = '0; m_crd = 0; m_err = 0;
      m_last = '0; m_done_cyc = -1;
    end else begin
      s_iss = m_issue();
      s_was = m_act;
      s_inf = 0;
      foreach (q[i])
        if (q[i].due >= cyc + 1 && q[i].due <= cyc + 2)
          s_inf = 1;
      if (q.size() > 0 && q[0].due == cyc) begin
        m_last = q[0].d;
        void'(q.pop_front());
        m_left--;
        if (m_left == 0) begin
          m_act = 0;
          m_done_cyc = cyc + 1;
        end
      end
      if (s_iss) begin
        q.push_back('{cyc + 3, mem[m_addr]});
        m_addr = m_addr + 1'b1;
        m_iss_left--;
      end
      if (!link_active && !s_inf) m_crd = 0;
      else if (txlcrdv && !s_iss) begin
        if (m_crd == 15) m_err = 1;
        else m_crd++;
      end else if (s_iss && !txlcrdv) m_crd--;
      if (!s_was && req_valid && req_count != 0) begin
        m_act = 1;
        m_addr = req_addr;
        m_iss_left = int'(req_count);
        m_left = int'(req_count);
      end
    end
    cyc++;
    started = 1;
  end

  logic          e_en, e_v, e_pend;
  logic [FW-1:0] e_d;

  always @(negedge clk) begin
    if (started) begin
      e_en   = m_issue();
      e_v    = q.size() > 0 && q[0].due == cyc;
      e_d    = e_v ? q[0].d : m_last;
      e_pend = (m_act && m_iss_left > 0) ||
               (q.size() > 0);
      chk("ram_en_b", 32'(ram_en_b), 32'(e_en));
      if (e_en)
        chk("ram_addr_b", 32'(ram_addr_b), 32'(m_addr));
      chk("txflitv", 32'(txflitv), 32'(e_v));
      chk("txflit", txflit, e_d);
      chk("txflitpend", 32'(txflitpend), 32'(e_pend));
      chk("req_ready", 32'(req_ready), 32'(!m_act));
      chk("done", 32'(done), 32'(cyc == m_done_cyc));
      chk("crd_avail", 32'(crd_avail), m_crd);
      chk("crd_err", 32'(crd_err), 32'(m_err));
      chk("oreg_ce", 32'(ram_oreg_ce_b), 32'd1);
    end
  end

  // Drive one cycle's inputs, then settle to mid-cycle
  task automatic tick(input logic rv,
                      input logic [AW-1:0] ra,
                      input logic [AW:0] rc,
                      input logic la,
                      input logic cr);
    @(posedge clk);
    #1;
    req_valid = rv; req_addr = ra; req_count = rc;
    link_active = la; txlcrdv = cr;
    #3;
  endtask

  task automatic idle(input logic la = 1'b1);
    tick(1'b0, '0, '0, la, 1'b0);
  endtask

  int nflit;

  task automatic wait_done(input int limit,
                           input int period);
    bit seen = 0;
    nflit = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      tick(1'b0, '0, '0, 1'b1,
           period > 0 && (n % period) == period - 1);
      if (txflitv) nflit++;
      if (done) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  int en_cnt, v_cnt;
  logic [AW-1:0] wa [4];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rst = 1'b1;
    req_valid = 0; req_addr = '0; req_count = '0;
    link_active = 0; txlcrdv = 0;
    repeat (3) idle(1'b0);
    rst = 1'b0;
    idle(1'b0);
    chk("rst_crd", 32'(crd_avail), 32'd0);
    chk("rst_err", 32'(crd_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_v", 32'(txflitv), 32'd0);
    chk("rst_oreg", 32'(ram_oreg_ce_b), 32'd1);

    repeat (15) tick(0, '0, '0, 1, 1);
    idle();
    chk("crd15", 32'(crd_avail), 32'd15);

    // single flit at slot 5
    tick(1, 4'd5, 5'd1, 1, 0);
    idle();
    chk("sf_en", 32'(ram_en_b), 32'd1);
    chk("sf_addr", 32'(ram_addr_b), 32'd5);
    idle();
    chk("sf_crd", 32'(crd_avail), 32'd14);
    idle();
    idle();
    chk("sf_v", 32'(txflitv), 32'd1);
    chk("sf_data", txflit, mem[5]);
    idle();
    chk("sf_done", 32'(done), 32'd1);
    chk("sf_ready", 32'(req_ready), 32'd1);

    // wrap burst 14,15,0,1 with a credit on first issue
    wa = '{4'd14, 4'd15, 4'd0, 4'd1};
    tick(1, 4'd14, 5'd4, 1, 0);
    tick(0, '0, '0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle();
      chk("wr_en", 32'(ram_en_b), 32'd1);
      chk("wr_addr", 32'(ram_addr_b), 32'(wa[i]));
      if (i == 1) chk("wr_crd", 32'(crd_avail), 32'd14);
      if (i == 3) chk("wr_v", 32'(txflitv), 32'd1);
      else chk("wr_pend", 32'(txflitpend), 32'd1);
    end
    for (int i = 1; i < 4; i++) begin
      idle();
      chk("wr_vn", 32'(txflitv), 32'd1);
      chk("wr_dn", txflit, mem[wa[i]]);
    end
    wait_done(10, 0);

    // starvation: 2 credits, then one per 10 cycles
    repeat (3) idle(1'b0);
    chk("stop_crd", 32'(crd_avail), 32'd0);
    repeat (2) tick(0, '0, '0, 1, 1);
    tick(1, 4'd9, 5'd5, 1, 0);
    wait_done(200, 10);
    chk("st_flits", nflit, 32'd5);

    // link drop after three issues
    repeat (2) idle(1'b0);
    repeat (15) tick(0, '0, '0, 1, 1);
    tick(1, 4'd3, 5'd8, 1, 0);
    repeat (3) idle();
    en_cnt = 0; v_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1'b0);
      if (ram_en_b) en_cnt++;
      if (txflitv) v_cnt++;
    end
    chk("ld_en", en_cnt, 32'd0);
    chk("ld_v", v_cnt, 32'd3);
    chk("ld_crd", 32'(crd_avail), 32'd0);
    wait_done(100, 3);
    chk("ld_flits", nflit, 32'd5);

    // reset during drain
    repeat (2) tick(0, '0, '0, 1, 1);
    tick(1, 4'd0, 5'd1, 1, 0);
    idle();
    idle();
    idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rm_v", 32'(txflitv), 32'd0);
    chk("rm_done", 32'(done), 32'd0);
    chk("rm_ready", 32'(req_ready), 32'd1);
    chk("rm_crd", 32'(crd_avail), 32'd0);
    idle();
    chk("rm_done2", 32'(done), 32'd0);

    // zero count is ignored
    tick(1, 4'd7, 5'd0, 1, 1);
    idle();
    chk("z_ready", 32'(req_ready), 32'd1);
    chk("z_en", 32'(ram_en_b), 32'd0);

    // overflow
    repeat (16) tick(0, '0, '0, 1, 1);
    idle();
    chk("of_crd", 32'(crd_avail), 32'd15);
    chk("of_err", 32'(crd_err), 32'd1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    idle();
    chk("of_clr", 32'(crd_err), 32'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      tick($urandom_range(0, 3) == 0,
           AW'($urandom),
           ($urandom_range(0, 9) == 0) ? 5'd0 :
             5'($urandom_range(1, 16)),
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) == 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 80; i++)
      tick(0, '0, '0, 1, i % 2 == 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
